mux_nch_rr: RTL and testbench

- Parametrised N-channel, DW-bit multiplexer with per-channel valid/ready handshakes and a registered output stage.
- Successor to the team's fixed 4:1 single-bit mux.
- Supports two select modes:
  - fixed: an external sel chooses the channel.
  - round-robin: an internal pointer chooses fairly among channels that have data.
- Sits between several producer streams and one consumer, for example a shared link or a debug tap.

---
 rtl/mux_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/mux_nch_rr.sv | 83 ++++++++
 tb/tb_mux_nch_rr.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the N-channel mux: select-mode encodings and a
// helper that pulls one channel's slice out of a packed multi-channel bus.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int SLICE_MAX_BUS = 1024;
  localparam int SLICE_MAX_DW  = 64;

  // Caller zero-extends the bus and truncates the result to its own width.
  function automatic logic [SLICE_MAX_DW-1:0] get_slice(
    input logic [SLICE_MAX_BUS-1:0] bus,
    input int                       dw,
    input int                       k
  );
    return SLICE_MAX_DW'(bus >> (k * dw));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// wrapping at NCH-1, and advances the pointer past the winner on adv.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int NCH  = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  req,
  input  logic            adv,
  output logic [SELW-1:0] grant,
  output logic            grant_valid
);

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] idx;

  // Walk offsets from the far end so the smallest offset from ptr wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = SELW'((int'(ptr) + i) % NCH);
      if (req[idx]) begin
        grant       = idx;
        grant_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (grant == SELW'(NCH - 1)) ? '0 : grant + SELW'(1);
    end
  end

endmodule

// File: rtl/mux_nch_rr.sv
// N-channel valid/ready multiplexer with fixed or round-robin channel
// selection and a single registered output slot.
module mux_nch_rr
  import mux_pkg::*;
#(
  parameter  int NCH  = 4,
  parameter  int DW   = 1,
  localparam int SELW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  output logic [DW-1:0]     out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SELW-1:0]   out_ch
);

  logic            ld;
  logic            fix_gv;
  logic            rr_gv;
  logic            gv_p0;
  logic [SELW-1:0] rr_g;
  logic [SELW-1:0] g_p0;
  logic [DW-1:0]   data_p0;
  logic            adv;

  logic            vld_p1;
  logic [DW-1:0]   data_p1;
  logic [SELW-1:0] ch_p1;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (in_valid),
    .adv         (adv),
    .grant       (rr_g),
    .grant_valid (rr_gv)
  );

  // Stage p0: grant selection and input handshake (combinational)
  always_comb begin
    ld     = !rst && (!vld_p1 || out_ready);
    fix_gv = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (sel == SELW'(k) && in_valid[k]) fix_gv = 1'b1;
    end
    gv_p0   = (mode == MODE_RR) ? rr_gv : fix_gv;
    g_p0    = (mode == MODE_RR) ? rr_g  : sel;
    data_p0 = DW'(get_slice(SLICE_MAX_BUS'(in_data), DW, int'(g_p0)));
    adv     = ld && gv_p0 && (mode == MODE_RR);
    in_ready = '0;
    for (int k = 0; k < NCH; k++) begin
      in_ready[k] = ld && gv_p0 && (g_p0 == SELW'(k));
    end
  end

  // Stage p1: output slot, holds under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
    end else if (ld) begin
      if (gv_p0) begin
        vld_p1  <= 1'b1;
        data_p1 <= data_p0;
        ch_p1   <= g_p0;
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_ch    = ch_p1;

endmodule

// File: tb/tb_mux_nch_rr.sv
// Bench for mux_nch_rr (NCH=4, DW=8): directed scenarios followed by random
// traffic, scored against a queue-based reference of the selection rules.
module tb_mux_nch_rr;

  localparam int NCH  = 4;
  localparam int DW   = 8;
  localparam int SELW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              mode;
  logic [SELW-1:0]   sel;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_valid;
  logic [NCH-1:0]    in_ready;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic [SELW-1:0]   out_ch;

  mux_nch_rr #(.NCH(NCH), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int data;
  } word_t;

  word_t          q[$];
  int             tests = 0;
  int             fails = 0;
  int             mptr  = 0;
  bit             mov   = 1'b0;
  logic [NCH-1:0] last_er = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: decides this cycle's grant from the rules and queues the word
  // that must later appear on the output.
  task automatic model_step();
    int             g;
    bit             gv;
    int             vi;
    logic [NCH-1:0] er;
    er = '0;
    gv = 1'b0;
    g  = 0;
    vi = int'(in_valid);
    if (rst) begin
      chk("rst_in_ready", 32'(in_ready), 32'(0));
      mptr    = 0;
      mov     = 1'b0;
      last_er = '0;
      q.delete();
      return;
    end
    chk("out_valid", 32'(out_valid), 32'(mov));
    if (!mode) begin
      if (int'(sel) < NCH && ((vi >> int'(sel)) & 1) == 1) begin
        gv = 1'b1;
        g  = int'(sel);
      end
    end else begin
      for (int i = 0; i < NCH && !gv; i++) begin
        if (((vi >> ((mptr + i) % NCH)) & 1) == 1) begin
          gv = 1'b1;
          g  = (mptr + i) % NCH;
        end
      end
    end
    if (!mov || out_ready) begin
      if (gv) begin
        word_t w;
        er     = 4'(1) << g;
        w.ch   = g;
        w.data = int'(in_data >> (g * DW)) & 32'hFF;
        q.push_back(w);
        mov = 1'b1;
        if (mode) mptr = (g + 1) % NCH;
      end else begin
        mov = 1'b0;
      end
    end
    chk("in_ready", 32'(in_ready), 32'(er));
    last_er = er;
  endtask

  task automatic cycle(input logic m, input logic [SELW-1:0] s, input logic [NCH-1:0] v,
                       input logic [NCH*DW-1:0] d, input logic ordy, input logic r = 1'b0);
    mode      = m;
    sel       = s;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    rst       = r;
    #1 model_step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every consumed output word must match the oldest queued word.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        chk("sb_underflow", 32'(q.size()), 32'(1));
      end else begin
        word_t w;
        w = q.pop_front();
        chk("sb_ch", 32'(out_ch), 32'(w.ch));
        chk("sb_data", 32'(out_data), 32'(w.data));
      end
    end
  end

  initial begin
    logic [NCH*DW-1:0] dd;
    logic [NCH*DW-1:0] rd;
    logic [NCH*DW-1:0] hmask;
    logic [NCH-1:0]    held;
    logic [NCH-1:0]    rv;
    dd        = 32'h44332211;
    rst       = 1'b1;
    mode      = 1'b0;
    sel       = '0;
    in_valid  = '1;
    in_data   = dd;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    cycle(1'b0, 2'd0, 4'hF, dd, 1'b1, 1'b1);
    cycle(1'b0, 2'd0, 4'hF, dd, 1'b1, 1'b1);
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_out_ch", 32'(out_ch), 32'(0));

    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < 10; c++) begin
        cycle(1'b0, SELW'(i % 4), 4'hF, dd, 1'b1);
        if (c == 0) begin
          chk("fix_data", 32'(out_data), 32'(8'h11 * ((i % 4) + 1)));
          chk("fix_ch", 32'(out_ch), 32'(i % 4));
        end
      end
    end

    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 2'd0, 4'hF, dd, 1'b1);
      chk("rr_fair_ch", 32'(out_ch), 32'(i % 4));
      chk("rr_fair_vld", 32'(out_valid), 32'(1));
    end

    cycle(1'b1, 2'd0, 4'b0100, dd, 1'b1);
    chk("rr_pre_ch", 32'(out_ch), 32'(2));
    cycle(1'b1, 2'd0, 4'b0101, dd, 1'b1);
    chk("rr_wrap_ch", 32'(out_ch), 32'(0));
    cycle(1'b1, 2'd0, 4'b0101, dd, 1'b1);
    chk("rr_skip_ch", 32'(out_ch), 32'(2));

    cycle(1'b0, 2'd1, 4'hF, dd, 1'b1);
    chk("bp_load", 32'(out_data), 32'(8'h22));
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 2'd1, 4'hF, dd, 1'b0);
      chk("bp_hold_data", 32'(out_data), 32'(8'h22));
      chk("bp_in_ready", 32'(in_ready), 32'(0));
    end
    cycle(1'b0, 2'd2, 4'hF, dd, 1'b1);
    chk("bp_release", 32'(out_data), 32'(8'h33));

    cycle(1'b0, 2'd2, 4'b1011, dd, 1'b1);
    chk("nogrant_vld", 32'(out_valid), 32'(0));

    cycle(1'b1, 2'd0, 4'hF, dd, 1'b1);
    chk("pre_rst_ch", 32'(out_ch), 32'(3));
    cycle(1'b1, 2'd0, 4'hF, dd, 1'b0, 1'b1);
    chk("midrst_vld", 32'(out_valid), 32'(0));
    cycle(1'b1, 2'd0, 4'hF, dd, 1'b1);
    chk("midrst_ptr", 32'(out_ch), 32'(0));

    for (int n = 0; n < 3000; n++) begin
      held  = in_valid & ~last_er;
      hmask = '0;
      for (int k = 0; k < NCH; k++) begin
        if (((int'(held) >> k) & 1) == 1) hmask = hmask | (32'hFF << (k * DW));
      end
      rv = NCH'($urandom_range(0, 15)) | held;
      rd = ($urandom() & ~hmask) | (in_data & hmask);
      cycle(1'($urandom_range(0, 1)), SELW'($urandom_range(0, 3)), rv, rd,
            $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
